fetch_ctrl: RTL and testbench

Fetch sequencer for the RV32 core. It owns the program counter and issues one instruction-memory request at a time, with a valid/ready handshake. Fetched words land in a small instruction buffer that feeds decode. Redirects from execute (taken branch, JAL, JALR) squash any stale in-flight fetch and flush the buffer.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_buf.sv | 54 +++++
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 fetch sequencer.
// Holds the FSM state encoding, the buffer entry layout and the PC alignment helper.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits carry no meaning.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small power-of-two FIFO of fetched {pc, inst} entries; the head is read
// straight from the storage registers. Flush empties it in one cycle.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_data,
  output fetch_entry_t             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// RV32 fetch sequencer: owns the PC, issues one imem request at a time and
// queues responses for decode. Redirects squash stale fetches and flush the buffer.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic [31:0] pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] req_pc;
  logic            req_fire;
  logic            has_credit;
  logic            push;
  logic            pop;
  logic [CNT_W-1:0] count;
  logic            empty;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  // A request is only issued when its response is guaranteed a buffer slot.
  assign has_credit = (count < CNT_W'(BUF_DEPTH));

  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req_valid = has_credit && !redirect_valid && !reset;
        if (!redirect_valid && imem_req_valid && imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          push    = !redirect_valid;
          state_d = FETCH;
        end else if (redirect_valid) begin
          state_d = SQUASH;
        end
      end
      SQUASH: begin
        if (imem_resp_valid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign req_fire = imem_req_valid && imem_req_ready;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (req_fire) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // Reset drops any outstanding request; a late response lands in FETCH and is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_pc  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (req_fire) begin
        req_pc <= pc_q;
      end
    end
  end

  assign wr_entry   = '{pc: req_pc, inst: imem_resp_data};
  assign inst_valid = !empty && !redirect_valid;
  assign pop        = inst_valid && inst_ready;

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (count),
    .empty   (empty)
  );

  assign imem_req_addr = pc_q;
  assign pc            = pc_q;
  assign inst_data     = head.inst;
  assign inst_pc       = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic, all
// checked against a transaction-level model (outstanding request + entry queue).
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] XORPAT   = 32'hA5A5A5A5;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] pc;

  fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .pc              (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit armed = 0;

  // Model: fetch address, at most one outstanding request (possibly squashed),
  // and the ordered list of fetched {pc, inst} awaiting decode.
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_sq;
  logic [31:0] m_out_addr;
  logic [63:0] m_q[$];
  // Environment memory: accepted addresses still owed a response, in order.
  logic [31:0] mem_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit rv, input logic [31:0] rpc,
                      input bit rdy, input bit want_resp, input bit ird);
    bit          exp_req;
    bit          exp_iv;
    bit          rsp_v;
    bit          fire_dut;
    logic [31:0] rsp_d;
    logic [31:0] fire_addr;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    inst_ready     = ird;
    rsp_v = want_resp && !rst && (mem_q.size() > 0);
    rsp_d = rsp_v ? (mem_q[0] ^ XORPAT) : 32'h0;
    imem_resp_valid = rsp_v;
    imem_resp_data  = rsp_d;
    #1;
    exp_req = !rst && !m_out && (m_q.size() < DEPTH) && !rv;
    exp_iv  = (m_q.size() > 0) && !rv;
    if (armed) begin
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
      chk("req_addr", imem_req_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
      if (exp_iv) begin
        chk("inst_pc", inst_pc, m_q[0][63:32]);
        chk("inst_data", inst_data, m_q[0][31:0]);
      end
    end
    fire_dut  = imem_req_valid && imem_req_ready;
    fire_addr = imem_req_addr;
    @(posedge clk);
    if (rsp_v) void'(mem_q.pop_front());
    if (fire_dut) mem_q.push_back(fire_addr);
    if (rst) begin
      m_pc  = RESET_PC;
      m_out = 0;
      m_sq  = 0;
      m_q.delete();
    end else if (rv) begin
      m_q.delete();
      m_pc = rpc & ~32'h3;
      if (m_out) begin
        if (rsp_v) m_out = 0;
        else       m_sq  = 1;
      end
    end else begin
      if (exp_iv && ird) void'(m_q.pop_front());
      if (m_out && rsp_v) begin
        if (!m_sq) m_q.push_back({m_out_addr, rsp_d});
        m_out = 0;
      end
      if (exp_req && rdy) begin
        m_out      = 1;
        m_sq       = 0;
        m_out_addr = m_pc;
        m_pc       = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
    m_pc = RESET_PC; m_out = 0; m_sq = 0; m_out_addr = '0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 1, 0, 0);
    armed = 1;
    step(1, 0, 0, 1, 0, 0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);

    // Basic stream, next-cycle responses
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    chk("first_valid", {31'b0, inst_valid}, 32'd1);
    chk("first_data", inst_data, 32'hA5A5A5A5);
    chk("first_pc", inst_pc, 32'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1);

    // Backpressure
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 0);
    chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("bp_pc", pc, 32'h8);
    chk("bp_head", inst_pc, 32'h0);
    step(0, 0, 0, 1, 0, 1);
    chk("drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("drain_addr", imem_req_addr, 32'h8);
    chk("drain_head", inst_pc, 32'h4);

    // Redirect while the request to 8 is outstanding
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 32'h100, 1, 0, 0);
    chk("sq_pc", pc, 32'h100);
    step(0, 0, 0, 1, 1, 1);
    chk("sq_done_req", {31'b0, imem_req_valid}, 32'd1);
    chk("sq_done_addr", imem_req_addr, 32'h100);
    chk("sq_no_stale", {31'b0, inst_valid}, 32'd0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1, 0);
    chk("redir_valid", {31'b0, inst_valid}, 32'd1);
    chk("redir_pc", inst_pc, 32'h100);
    chk("redir_data", inst_data, 32'hA5A5A4A5);

    // Redirect coincident with the response
    step(0, 0, 0, 1, 0, 1);
    step(0, 1, 32'h203, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("co_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("co_addr", imem_req_addr, 32'h200);
    chk("co_no_stale", {31'b0, inst_valid}, 32'd0);

    // Reset mid-WAIT, then the old response arrives
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("rw_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rw_addr", imem_req_addr, RESET_PC);
    chk("rw_no_inst", {31'b0, inst_valid}, 32'd0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("rw_inst_pc", inst_pc, 32'h0);
    chk("rw_inst_data", inst_data, 32'hA5A5A5A5);

    // Wrap with a stalling imem
    step(0, 1, 32'hFFFF_FFFC, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("stall_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_req_addr, 32'hFFFF_FFFC);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("wrap_pc", pc, 32'h0);
    step(0, 0, 0, 1, 1, 0);
    chk("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap_addr", imem_req_addr, 32'h0);
    chk("wrap_head", inst_pc, 32'hFFFF_FFFC);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
      step($urandom_range(99) == 0, $urandom_range(11) == 0, rpc,
           $urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
